// File: rtl/brightness_pkg.sv
// -----------------------------------------------------------------------------
// brightness_pkg
// Shared types and constants for the brightness command readers.
//   brightness_cmd_state_t : command-reader FSM states
//   BRIGHTNESS_BROADCAST   : channel-select value that addresses every channel
// -----------------------------------------------------------------------------
package brightness_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_VALUE = 2'd1,
    ST_DONE       = 2'd2
  } brightness_cmd_state_t;

  localparam logic [7:0] BRIGHTNESS_BROADCAST = 8'hFF;

endpackage

// File: rtl/cmd_idle_timeout.sv
// -----------------------------------------------------------------------------
// cmd_idle_timeout
// Idle-gap watchdog for multi-byte command readers. Counts cycles in which the
// reader waits for its next byte and flags the cycle on which the count would
// reach TIMEOUT_CYCLES. TIMEOUT_CYCLES = 0 disables the watchdog.
// Ports:
//   clk_i       clock
//   reset_i     asynchronous active-high reset
//   clear_i     restart the count (takes priority over count_en_i)
//   count_en_i  this cycle is an idle cycle
//   expired_o   the idle count reaches TIMEOUT_CYCLES on the coming edge
// -----------------------------------------------------------------------------
module cmd_idle_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic             TMO_ON   = (TIMEOUT_CYCLES != 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter saturates at TIMEOUT_CYCLES so a stalled reader never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Look-ahead: fire on the idle cycle whose edge brings the count to
  // TIMEOUT_CYCLES, so the reader's registered done/error rise on that edge.
  assign expired_o = TMO_ON && count_en_i && !clear_i && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/control_cmd_readbrightness_multi.sv
// -----------------------------------------------------------------------------
// control_cmd_readbrightness_multi
// Multi-channel brightness command reader. Takes a channel-select byte and a
// value byte from the control dispatcher and writes one channel, all channels
// (select 0xFF) or nothing (select out of range -> error). A stalled command
// is abandoned after TIMEOUT_CYCLES idle cycles with done+error.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   data_in, enable         payload byte and its one-cycle strobe
//   brightness_out          packed channel registers, channel k at [k*BL +: BL]
//   brightness_change_mask  one-cycle pulse, bit per channel written
//   brightness_change_en    one-cycle pulse, OR of the mask
//   done, error             one-cycle end-of-command / rejected-command pulses
//   busy                    command in progress
// -----------------------------------------------------------------------------
module control_cmd_readbrightness_multi
  import brightness_pkg::*;
#(
  parameter int unsigned BRIGHTNESS_LEVELS = 8,
  parameter int unsigned CHANNELS          = 4,
  parameter int unsigned TIMEOUT_CYCLES    = 1024,
  parameter logic [BRIGHTNESS_LEVELS-1:0] BRIGHTNESS_RESET = '1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [7:0]                             data_in,
  input  logic                                   enable,
  output logic [CHANNELS*BRIGHTNESS_LEVELS-1:0]  brightness_out,
  output logic [CHANNELS-1:0]                    brightness_change_mask,
  output logic                                   brightness_change_en,
  output logic                                   done,
  output logic                                   error,
  output logic                                   busy
);

  localparam int unsigned BL = BRIGHTNESS_LEVELS;

  brightness_cmd_state_t state_q, state_d;
  logic [7:0]             chan_sel_q, chan_sel_d;
  logic [CHANNELS*BL-1:0] bright_q, bright_d;
  logic [CHANNELS-1:0]    mask_q, mask_d;
  logic                   en_q, en_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic                   busy_q, busy_d;

  logic                   tmo_clear;
  logic                   tmo_count;
  logic                   tmo_expired;
  logic [CHANNELS-1:0]    sel_mask;

  // Channel-select decode: broadcast hits every channel, an out-of-range
  // select hits none (which is what flags the error).
  function automatic logic [CHANNELS-1:0] decode_sel(input logic [7:0] sel);
    logic [CHANNELS-1:0] m;
    m = '0;
    if (sel == BRIGHTNESS_BROADCAST) begin
      m = '1;
    end else begin
      for (int k = 0; k < int'(CHANNELS); k++) begin
        if (sel == 8'(k)) m[k] = 1'b1;
      end
    end
    return m;
  endfunction

  assign sel_mask  = decode_sel(chan_sel_q);
  assign tmo_clear = (state_q == ST_IDLE) && enable;
  assign tmo_count = (state_q == ST_WAIT_VALUE) && !enable;

  cmd_idle_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_idle_timeout (
    .clk_i      (clk),
    .reset_i    (reset),
    .clear_i    (tmo_clear),
    .count_en_i (tmo_count),
    .expired_o  (tmo_expired)
  );

  always_comb begin
    state_d    = state_q;
    chan_sel_d = chan_sel_q;
    bright_d   = bright_q;
    mask_d     = '0;
    en_d       = 1'b0;
    done_d     = 1'b0;
    error_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          chan_sel_d = data_in;
          state_d    = ST_WAIT_VALUE;
        end
      end
      ST_WAIT_VALUE: begin
        // A value byte on the timeout edge still counts as a normal value.
        if (enable) begin
          for (int k = 0; k < int'(CHANNELS); k++) begin
            if (sel_mask[k]) bright_d[k*BL +: BL] = data_in[BL-1:0];
          end
          mask_d  = sel_mask;
          en_d    = |sel_mask;
          error_d = ~|sel_mask;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (tmo_expired) begin
          done_d  = 1'b1;
          error_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Any strobe here is dropped; pulses fall via the defaults above.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      chan_sel_q <= '0;
      bright_q   <= {CHANNELS{BRIGHTNESS_RESET}};
      mask_q     <= '0;
      en_q       <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      chan_sel_q <= chan_sel_d;
      bright_q   <= bright_d;
      mask_q     <= mask_d;
      en_q       <= en_d;
      done_q     <= done_d;
      error_q    <= error_d;
      busy_q     <= busy_d;
    end
  end

  assign brightness_out         = bright_q;
  assign brightness_change_mask = mask_q;
  assign brightness_change_en   = en_q;
  assign done                   = done_q;
  assign error                  = error_q;
  assign busy                   = busy_q;

endmodule

// File: tb/tb_control_cmd_readbrightness_multi.sv
// -----------------------------------------------------------------------------
// tb_control_cmd_readbrightness_multi
// Scoreboard bench: the driver issues commands and pushes the expected
// end-of-command response computed from a channel-array model; a monitor pops
// and compares whenever done is seen, and flags any output activity between
// commands.
// -----------------------------------------------------------------------------
module tb_control_cmd_readbrightness_multi;

  localparam int BL   = 8;
  localparam int NCH  = 4;
  localparam int TMO  = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [7:0]       data_in = 8'h00;
  logic             enable = 1'b0;
  logic [NCH*BL-1:0] brightness_out;
  logic [NCH-1:0]   brightness_change_mask;
  logic             brightness_change_en;
  logic             done;
  logic             error;
  logic             busy;

  control_cmd_readbrightness_multi #(
    .BRIGHTNESS_LEVELS (BL),
    .CHANNELS          (NCH),
    .TIMEOUT_CYCLES    (TMO)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .data_in                (data_in),
    .enable                 (enable),
    .brightness_out         (brightness_out),
    .brightness_change_mask (brightness_change_mask),
    .brightness_change_en   (brightness_change_en),
    .done                   (done),
    .error                  (error),
    .busy                   (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH*BL-1:0] br;
    logic [NCH-1:0]    mask;
    logic              en;
    logic              err;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mch[NCH];
  int         n_checks = 0;
  int         n_err    = 0;
  int         n_done_exp = 0;
  int         n_done_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [NCH*BL-1:0] pack_model();
    logic [NCH*BL-1:0] v;
    for (int k = 0; k < NCH; k++) v[k*BL +: BL] = mch[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) mch[k] = 8'hFF;
  endtask

  // Reference model: apply one command to the channel array and queue the
  // response the DUT should show when it raises done.
  task automatic model_cmd(input logic [7:0] sel, input logic [7:0] val, input int gap);
    exp_t e;
    e.mask = '0;
    e.err  = 1'b0;
    if (gap >= TMO) begin
      e.err = 1'b1;
    end else if (sel == 8'hFF) begin
      for (int k = 0; k < NCH; k++) begin
        mch[k] = val;
        e.mask[k] = 1'b1;
      end
    end else if (int'(sel) < NCH) begin
      mch[int'(sel)] = val;
      e.mask[int'(sel)] = 1'b1;
    end else begin
      e.err = 1'b1;
    end
    e.en = (e.mask != '0);
    e.br = pack_model();
    exp_q.push_back(e);
    n_done_exp++;
  endtask

  // Select byte, `gap` idle cycles, then the value byte (or a timeout when
  // gap reaches TMO), then the DONE cycle, optionally with a stray strobe.
  task automatic send_cmd(input logic [7:0] sel, input logic [7:0] val, input int gap,
                          input bit stray);
    model_cmd(sel, val, gap);
    @(negedge clk);
    chk("busy_before_cmd", 64'(busy), 64'd0);
    enable  = 1'b1;
    data_in = sel;
    @(negedge clk);
    chk("busy_after_select", 64'(busy), 64'd1);
    if (gap >= TMO) begin
      enable  = 1'b0;
      data_in = 8'($urandom);
      repeat (TMO) @(negedge clk);
    end else begin
      for (int i = 0; i < gap; i++) begin
        enable  = 1'b0;
        data_in = 8'($urandom);
        @(negedge clk);
      end
      enable  = 1'b1;
      data_in = val;
      @(negedge clk);
    end
    enable  = stray;
    data_in = 8'($urandom);
    if (stray) begin
      @(negedge clk);
      enable = 1'b0;
    end
  endtask

  task automatic mid_reset();
    @(negedge clk);
    enable  = 1'b1;
    data_in = 8'h00;
    @(negedge clk);
    enable = 1'b0;
    chk("busy_before_mid_reset", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("busy_mid_reset", 64'(busy), 64'd0);
    chk("done_mid_reset", 64'(done), 64'd0);
    chk("bright_mid_reset", 64'(brightness_out), 64'(pack_model()));
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  // Monitor: pops one expectation per done and polices quiet cycles.
  logic [NCH*BL-1:0] prev_br;
  logic              prev_done = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_br   = brightness_out;
      prev_done = 1'b0;
    end else begin
      if (done) begin
        n_done_seen++;
        chk("done_width", 64'(prev_done), 64'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("bright", 64'(brightness_out), 64'(e.br));
          chk("mask", 64'(brightness_change_mask), 64'(e.mask));
          chk("change_en", 64'(brightness_change_en), 64'(e.en));
          chk("error", 64'(error), 64'(e.err));
        end
      end else begin
        if (brightness_change_en || error || (brightness_change_mask != '0)) begin
          chk("stray_pulse", {brightness_change_mask, brightness_change_en, error}, 64'd0);
        end
        if (brightness_out !== prev_br) begin
          chk("bright_hold", 64'(brightness_out), 64'(prev_br));
        end
      end
      prev_br   = brightness_out;
      prev_done = done;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sel, val;
    int gap;
    model_reset();
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("reset_bright", 64'(brightness_out), 64'(pack_model()));
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_pulses", {brightness_change_mask, brightness_change_en, done, error}, 64'd0);

    send_cmd(8'h02, 8'h5A, 0, 1'b0);
    send_cmd(8'hFF, 8'h10, 0, 1'b0);
    send_cmd(8'h07, 8'h33, 0, 1'b0);
    send_cmd(8'h01, 8'hC3, TMO, 1'b0);
    send_cmd(8'h01, 8'h77, TMO - 1, 1'b0);
    send_cmd(8'h03, 8'h21, 2, 1'b1);
    mid_reset();
    send_cmd(8'h00, 8'h80, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0:       sel = 8'hFF;
        1:       sel = 8'($urandom_range(4, 254));
        default: sel = 8'($urandom_range(0, NCH - 1));
      endcase
      val = 8'($urandom);
      case ($urandom_range(0, 9))
        0:       gap = TMO;
        1:       gap = TMO - 1;
        default: gap = $urandom_range(0, 4);
      endcase
      send_cmd(sel, val, gap, ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("done_count", 64'(n_done_seen), 64'(n_done_exp));
    chk("final_bright", 64'(brightness_out), 64'(pack_model()));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/control_cmd_readbrightness_multi.md
# control_cmd_readbrightness_multi

Per-channel brightness command reader for the LED display control path, generalising the single-byte brightness command to CHANNELS independently addressable brightness registers. The control dispatcher forwards the command's payload bytes, one byte per `enable` strobe: a channel-select byte, then a value byte. The block updates one channel or all channels and signals completion to the dispatcher. An idle-timeout recovers from truncated commands.

## Interface
- `BRIGHTNESS_LEVELS`, from shared params (8): brightness width in bits, ≤ 8.
- `CHANNELS`, 4: number of brightness registers, 1..254.
- `TIMEOUT_CYCLES`, 1024: max idle cycles between the select byte and the value byte; 0 disables the timeout.
- `BRIGHTNESS_RESET`, all ones: reset value of every channel register.
- `clk`  in  1  single clock for the whole block.
- `reset`  in  1  asynchronous, active-high reset.
- `data_in`  in  8  payload byte, valid when `enable` is high.
- `enable`  in  1  byte strobe from the dispatcher, one cycle per byte.
- `brightness_out`  out  CHANNELS*BRIGHTNESS_LEVELS  packed channel registers; channel k occupies bits [k*BL +: BL].
- `brightness_change_mask`  out  CHANNELS  one-cycle pulse, with one bit set per channel written.
- `brightness_change_en`  out  1  one-cycle pulse, equal to the OR of the mask.
- `done`  out  1  one-cycle pulse marking the end of the command.
- `error`  out  1  one-cycle pulse, coincident with `done`, for a rejected or timed-out command.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, WAIT_VALUE, DONE.
- IDLE + `enable`: latch `data_in` into `chan_sel`, clear the timeout counter, go to WAIT_VALUE.
- WAIT_VALUE + `enable`: compute `value = data_in[BL-1:0]` (upper bits ignored). Then:
  - `chan_sel == 8'hFF`: write all channels; mask is all ones.
  - `chan_sel < CHANNELS`: write that channel only; its mask bit is set.
  - otherwise: write nothing; mask is 0 and `error` = 1.
  - In all three cases assert `done`, then go to DONE.
- WAIT_VALUE, no `enable`: increment the counter. When the counter reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES ≠ 0): assert `done` and `error`, write nothing, go to DONE.
- DONE: clear `done`, `error`, the mask and `brightness_change_en`; go to IDLE. `enable` in DONE is ignored and the byte is dropped; the dispatcher must not strobe here.
- Channel registers persist between commands. Only the reset and the write rules above change them.
- Reset values:
  - `brightness_out` = BRIGHTNESS_RESET replicated.
  - `done`, `error`, `brightness_change_en`, mask = 0.
  - `busy` = 0, state = IDLE, counter = 0, `chan_sel` = 0.
- Reset asserted mid-command: the command is abandoned immediately, no pulse is emitted, and the registers return to reset values.

## Timing
- All outputs are registered.
- `brightness_out`, the mask, `brightness_change_en`, `done` and `error` all change on the same edge that samples the value byte.
- Latency: 1 cycle from the value-byte `enable` edge to `done`.
- Minimum command length is 3 cycles (select, value, DONE). `busy` is high from the cycle after the select byte until the cycle after `done`.
- Back-to-back: a new select byte is accepted in the first IDLE cycle after DONE.
- Timeout: `done`/`error` rise on the edge where the idle count reaches TIMEOUT_CYCLES. A strobe arriving on that same edge wins: the command is treated as a normal value byte.
- Counter width is $clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.

## Structure
- Shared package `brightness_pkg`: the state enum `brightness_cmd_state_t` and the constant `BRIGHTNESS_BROADCAST = 8'hFF`.
- Sub-module `cmd_idle_timeout`:
  - Inputs: clear, count-enable.
  - Output: expired.
  - Parameter: TIMEOUT_CYCLES.
  - Reusable by the other multi-byte command readers.

## Test plan
- Reset check: `brightness_out` is all ones, all pulses are 0 and `busy` = 0.
- CHANNELS=4: bytes 0x02 then 0x5A → ch2 = 0x5A, mask = 4'b0100, `done` and `brightness_change_en` high for exactly 1 cycle, other channels unchanged.
- Bytes 0xFF then 0x10 → all 4 channels = 0x10, mask = 4'b1111, `error` = 0.
- Bytes 0x07 then 0x33 → no register change, mask = 0, `done` = `error` = 1 for one cycle.
- TIMEOUT_CYCLES=16: byte 0x01, then 16 idle cycles → `done` = `error` = 1 with no change. Repeat with the value byte arriving on the 16th idle cycle → normal update of ch1.
- Reset asserted while in WAIT_VALUE after select 0x00 → immediate IDLE, no `done`. A subsequent 0x00, 0x80 command writes ch0 = 0x80.
